decoder_scan_nto2n: RTL and testbench

//  Registered, parametrised SEL_W-to-2^SEL_W one-hot decoder with a built-in scan sequencer.

---
 rtl/decoder_scan_nto2n.sv | 134 +++++++++++++
 tb/tb_decoder_scan_nto2n.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_nto2n.sv
// decoder_scan_nto2n: registered SEL_W-to-2^SEL_W one-hot decoder with a scan sequencer.
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   en           block enable (0 forces IDLE)
//   mode         00 DECODE, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD
//   s            decode select / scan start index (with load)
//   load         scan-only pulse: idx <= s, counter cleared
//   dwell        each scan index is held for dwell+1 cycles
//   o            registered one-hot output (inverted when ACTIVE_LOW)
//   idx          index currently driven on o
//   valid        o carries a decoded line
//   wrap         one-cycle pulse on the edge idx wraps
module decoder_scan_nto2n #(
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned DWELL_W    = 8,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      s,
  input  logic                  load,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(2**SEL_W)-1:0] o,
  output logic [SEL_W-1:0]      idx,
  output logic                  valid,
  output logic                  wrap
);

  localparam int unsigned OUT_W = 2**SEL_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_SCAN_UP,
    ST_SCAN_DOWN,
    ST_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;
  logic [OUT_W-1:0]   o_q, o_d;
  logic [OUT_W-1:0]   onehot_c;

  // State, index and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      o_q     <= {OUT_W{ACTIVE_LOW}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      o_q     <= o_d;
    end
  end

  // Next state is chosen from en/mode every cycle; per-state update of idx/counter
  always_comb begin
    state_d  = ST_IDLE;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    wrap_d   = 1'b0;
    onehot_c = '0;
    o_d      = '0;

    if (en) begin
      case (mode)
        2'b00:   state_d = ST_DECODE;
        2'b01:   state_d = ST_SCAN_UP;
        2'b10:   state_d = ST_SCAN_DOWN;
        default: state_d = ST_HOLD;
      endcase
    end

    case (state_d)
      ST_DECODE: begin
        idx_d   = s;
        cnt_d   = '0;
        valid_d = 1'b1;
      end
      ST_SCAN_UP, ST_SCAN_DOWN: begin
        valid_d = 1'b1;
        if (load) begin
          // load wins over both scan entry and a due step
          idx_d = s;
          cnt_d = '0;
        end else if (state_q != state_d) begin
          // scan entry (incl. direction change): restart dwell, keep index
          cnt_d = '0;
        end else if (cnt_q >= dwell) begin
          cnt_d = '0;
          if (state_d == ST_SCAN_UP) begin
            idx_d  = idx_q + SEL_W'(1);
            wrap_d = &idx_q;
          end else begin
            idx_d  = idx_q - SEL_W'(1);
            wrap_d = ~|idx_q;
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      ST_HOLD: begin
        // frozen; valid stays 0 when HOLD is entered straight from IDLE
        valid_d = valid_q;
      end
      default: begin
      end
    endcase

    if (valid_d) begin
      onehot_c = OUT_W'(1) << idx_d;
    end
    o_d = ACTIVE_LOW ? ~onehot_c : onehot_c;
  end

  assign o     = o_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Testbench for decoder_scan_nto2n: scoreboard of model-predicted outputs per clock,
// plus spec-literal expectations for the named scenarios. A second instance with
// ACTIVE_LOW=1 shares all inputs and is checked against the inverted prediction.
module tb_decoder_scan_nto2n;

  localparam int unsigned SEL_W   = 3;
  localparam int unsigned DWELL_W = 8;
  localparam int unsigned OUT_W   = 8;

  logic               clk;
  logic               rst;
  logic               en;
  logic [1:0]         mode;
  logic [SEL_W-1:0]   s;
  logic               load;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   o, o_al;
  logic [SEL_W-1:0]   idx, idx_al;
  logic               valid, valid_al;
  logic               wrap, wrap_al;

  typedef struct {
    logic [OUT_W-1:0] o;
    logic [SEL_W-1:0] idx;
    logic             valid;
    logic             wrap;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int checks;
  int failures;

  // reference model state
  int m_st;   // 0 idle, 1 decode, 2 up, 3 down, 4 hold
  int m_idx;
  int m_cnt;
  bit m_valid;
  bit m_wrap;

  decoder_scan_nto2n #(.SEL_W(SEL_W), .DWELL_W(DWELL_W), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .load(load), .dwell(dwell),
    .o(o), .idx(idx), .valid(valid), .wrap(wrap)
  );

  decoder_scan_nto2n #(.SEL_W(SEL_W), .DWELL_W(DWELL_W), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .load(load), .dwell(dwell),
    .o(o_al), .idx(idx_al), .valid(valid_al), .wrap(wrap_al)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_st = 0; m_idx = 0; m_cnt = 0; m_valid = 1'b0; m_wrap = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle of inputs, push the predicted result, sample #1 after the edge
  task automatic drive(input logic ev, input logic [1:0] mv, input logic [2:0] sv,
                       input logic lv, input logic [7:0] dv);
    int   nst;
    exp_t x;
    en = ev; mode = mv; s = sv; load = lv; dwell = dv;
    nst = !ev ? 0 : (mv == 2'd0) ? 1 : (mv == 2'd1) ? 2 : (mv == 2'd2) ? 3 : 4;
    m_wrap = 1'b0;
    if (nst == 0) begin
      m_valid = 1'b0;
    end else if (nst == 1) begin
      m_idx = int'(sv); m_cnt = 0; m_valid = 1'b1;
    end else if (nst == 2 || nst == 3) begin
      m_valid = 1'b1;
      if (lv) begin
        m_idx = int'(sv); m_cnt = 0;
      end else if (m_st != nst) begin
        m_cnt = 0;
      end else if (m_cnt >= int'(dv)) begin
        m_cnt = 0;
        if (nst == 2) begin
          m_wrap = (m_idx == 7);
          m_idx  = (m_idx + 1) % 8;
        end else begin
          m_wrap = (m_idx == 0);
          m_idx  = (m_idx + 7) % 8;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    m_st    = nst;
    x.idx   = 3'(m_idx);
    x.valid = m_valid;
    x.wrap  = m_wrap;
    x.o     = m_valid ? (8'd1 << m_idx) : 8'h00;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 2'b00; s = '0; load = 1'b0; dwell = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (o !== 8'h00 || o_al !== 8'hFF || idx !== 3'd0 || valid !== 1'b0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset: o=%h o_al=%h idx=%0d valid=%b wrap=%b, required o=00 o_al=ff idx=0 valid=0 wrap=0",
               o, o_al, idx, valid, wrap);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_decode();
    logic [7:0] lit [3];
    logic [2:0] sel [3];
    lit[0] = 8'b0000_1000; lit[1] = 8'b0100_0000; lit[2] = 8'b1000_0000;
    sel[0] = 3'd3; sel[1] = 3'd6; sel[2] = 3'd7;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, sel[i], 1'b0, 8'd0);
      e = sb.pop_front();
      checks++;
      if (o !== e.o || o !== lit[i] || idx !== sel[i] || valid !== 1'b1 || wrap !== 1'b0 ||
          o_al !== ~e.o) begin
        failures++;
        $display("FAIL decode[%0d]: o=%h o_al=%h idx=%0d valid=%b wrap=%b, required o=%h idx=%0d valid=1 wrap=0",
                 i, o, o_al, idx, valid, wrap, lit[i], sel[i]);
      end
    end
  endtask

  task automatic test_scan_up_wrap();
    logic [2:0] li [4];
    logic       lw [4];
    li[0] = 3'd6; li[1] = 3'd7; li[2] = 3'd0; li[3] = 3'd1;
    lw[0] = 1'b0; lw[1] = 1'b0; lw[2] = 1'b1; lw[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b01, 3'd6, (i == 0), 8'd0);
      e = sb.pop_front();
      checks++;
      if (idx !== li[i] || wrap !== lw[i] || o !== e.o || valid !== e.valid || idx !== e.idx ||
          wrap !== e.wrap || o_al !== ~e.o) begin
        failures++;
        $display("FAIL scan_up[%0d]: idx=%0d wrap=%b o=%h, required idx=%0d wrap=%b o=%h",
                 i, idx, wrap, o, li[i], lw[i], e.o);
      end
    end
  endtask

  task automatic test_scan_down();
    logic [2:0] li [9];
    li[0] = 3'd1; li[1] = 3'd1; li[2] = 3'd1; li[3] = 3'd0; li[4] = 3'd0;
    li[5] = 3'd0; li[6] = 3'd7; li[7] = 3'd7; li[8] = 3'd7;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 2'b10, 3'd1, (i == 0), 8'd2);
      e = sb.pop_front();
      checks++;
      if (idx !== li[i] || wrap !== (i == 6) || (i >= 6 && o !== 8'b1000_0000) || o !== e.o ||
          valid !== e.valid || wrap !== e.wrap || o_al !== ~e.o) begin
        failures++;
        $display("FAIL scan_down[%0d]: idx=%0d wrap=%b o=%h, required idx=%0d wrap=%b o=%h",
                 i, idx, wrap, o, li[i], (i == 6), e.o);
      end
    end
  endtask

  task automatic test_hold();
    // reach idx=4 in SCAN_UP with dwell=3, hold 5 clks, then scan again
    for (int i = 0; i < 12; i++) begin
      logic [1:0] mv;
      mv = (i >= 2 && i < 7) ? 2'b11 : 2'b01;
      drive(1'b1, mv, 3'd4, (i == 0), 8'd3);
      e = sb.pop_front();
      checks++;
      if (o !== e.o || idx !== e.idx || valid !== e.valid || wrap !== e.wrap || o_al !== ~e.o ||
          (i >= 2 && i < 7 && o !== 8'b0001_0000) || (i == 11 && idx !== 3'd5) ||
          (i >= 7 && i < 11 && idx !== 3'd4)) begin
        failures++;
        $display("FAIL hold[%0d]: o=%h idx=%0d valid=%b wrap=%b, required o=%h idx=%0d valid=%b wrap=%b",
                 i, o, idx, valid, wrap, e.o, e.idx, e.valid, e.wrap);
      end
    end
  endtask

  task automatic test_load_and_dwell();
    // load coincident with a due step, then a live dwell reduction
    for (int i = 0; i < 10; i++) begin
      logic       lv;
      logic [7:0] dv;
      lv = (i == 2);
      dv = (i < 4) ? 8'd0 : (i < 8) ? 8'd6 : 8'd1;
      drive(1'b1, 2'b01, 3'd2, lv, dv);
      e = sb.pop_front();
      checks++;
      if (o !== e.o || idx !== e.idx || valid !== e.valid || wrap !== e.wrap || o_al !== ~e.o ||
          (i == 2 && idx !== 3'd2)) begin
        failures++;
        $display("FAIL load_dwell[%0d]: o=%h idx=%0d wrap=%b, required o=%h idx=%0d wrap=%b",
                 i, o, idx, wrap, e.o, e.idx, e.wrap);
      end
    end
  endtask

  task automatic test_idle_hold();
    // en=0 idles with idx retained; HOLD straight from IDLE stays invalid
    logic [1:0] mv [6];
    logic       ev [6];
    ev[0] = 1'b1; ev[1] = 1'b0; ev[2] = 1'b1; ev[3] = 1'b1; ev[4] = 1'b0; ev[5] = 1'b1;
    mv[0] = 2'b00; mv[1] = 2'b00; mv[2] = 2'b11; mv[3] = 2'b10; mv[4] = 2'b01; mv[5] = 2'b00;
    for (int i = 0; i < 6; i++) begin
      drive(ev[i], mv[i], 3'd5, 1'b1, 8'd0);
      e = sb.pop_front();
      checks++;
      if (o !== e.o || idx !== e.idx || valid !== e.valid || wrap !== e.wrap || o_al !== ~e.o ||
          (i == 0 && o_al !== 8'b1101_1111) || (i == 1 && (o_al !== 8'hFF || valid !== 1'b0))) begin
        failures++;
        $display("FAIL idle_hold[%0d]: o=%h o_al=%h idx=%0d valid=%b, required o=%h idx=%0d valid=%b",
                 i, o, o_al, idx, valid, e.o, e.idx, e.valid);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 2'b01, 3'd3, 1'b1, 8'd0);
    e = sb.pop_front();
    drive(1'b1, 2'b01, 3'd3, 1'b0, 8'd0);
    e = sb.pop_front();
    checks++;
    if (idx !== 3'd4 || valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: idx=%0d valid=%b, required idx=4 valid=1", idx, valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (o !== 8'h00 || o_al !== 8'hFF || valid !== 1'b0 || idx !== 3'd0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: o=%h o_al=%h idx=%0d valid=%b, required o=00 o_al=ff idx=0 valid=0",
               o, o_al, idx, valid);
    end
    load = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if (valid !== 1'b0 || idx !== 3'd0) begin
      failures++;
      $display("FAIL reset_held: idx=%0d valid=%b, required idx=0 valid=0", idx, valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b01, 3'd0, 1'b0, 8'd0);
      e = sb.pop_front();
      checks++;
      if (o !== e.o || idx !== e.idx || valid !== e.valid || wrap !== e.wrap || o_al !== ~e.o) begin
        failures++;
        $display("FAIL resume[%0d]: o=%h idx=%0d valid=%b, required o=%h idx=%0d valid=%b",
                 i, o, idx, valid, e.o, e.idx, e.valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      logic       ev;
      logic [1:0] mv;
      logic [2:0] sv;
      logic       lv;
      logic [7:0] dv;
      ev = ($urandom_range(0, 9) != 0);
      mv = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : mode;
      sv = 3'($urandom_range(0, 7));
      lv = ($urandom_range(0, 7) == 0);
      dv = 8'($urandom_range(0, 3));
      drive(ev, mv, sv, lv, dv);
      e = sb.pop_front();
      checks++;
      if (o !== e.o || idx !== e.idx || valid !== e.valid || wrap !== e.wrap || o_al !== ~e.o) begin
        failures++;
        $display("FAIL random[%0d]: o=%h idx=%0d valid=%b wrap=%b, required o=%h idx=%0d valid=%b wrap=%b",
                 i, o, idx, valid, wrap, e.o, e.idx, e.valid, e.wrap);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_decode();
    test_scan_up_wrap();
    test_scan_down();
    test_hold();
    test_load_and_dwell();
    test_idle_hold();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
